pipeline: RTL and testbench

- Parameterizable fixed-latency delay line: input word d appears unchanged on q exactly Depth clock cycles later.
- No handshake and no stall; the block samples d on every rising edge of clk.
- Used to latency-balance datapaths elsewhere in the design.
- Depth=0 degenerates to a combinational pass-through.

---
 rtl/pipeline_stage.sv | 22 ++
 rtl/pipeline.sv | 42 ++++
 tb/tb_pipeline.sv | 116 +++++++++++
 3 files changed

// File: rtl/pipeline_stage.sv
// One register stage of the delay line: a Width-bit flop that clears to zero on a synchronous reset.
module pipeline_stage #(
  parameter int Width = 15
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [Width-1:0] d,
  output logic [Width-1:0] q
);

  logic [Width-1:0] data_q;
  logic [Width-1:0] data_d;

  assign data_d = rst ? '0 : d;

  always_ff @(posedge clk) begin
    data_q <= data_d;
  end

  assign q = data_q;

endmodule

// File: rtl/pipeline.sv
// Fixed-latency delay line: q is d delayed by Depth cycles, with no handshake and no stall.
// Depth=0 is a pure combinational pass-through that ignores clk and rst.
module pipeline #(
  parameter int Width = 15,
  parameter int Depth = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [Width-1:0] d,
  output logic [Width-1:0] q
);

  if (Depth == 0) begin : g_pass
    // clk and rst have no function here; fold them into a sink so the port list stays uniform.
    logic unused_clk_rst;
    assign unused_clk_rst = clk ^ rst;
    assign q = d;
  end else begin : g_chain
    logic [Width-1:0] stage_q [Depth];

    for (genvar i = 0; i < Depth; i++) begin : g_stage
      if (i == 0) begin : g_head
        pipeline_stage #(.Width(Width)) u_stage (
          .clk (clk),
          .rst (rst),
          .d   (d),
          .q   (stage_q[i])
        );
      end else begin : g_body
        pipeline_stage #(.Width(Width)) u_stage (
          .clk (clk),
          .rst (rst),
          .d   (stage_q[i-1]),
          .q   (stage_q[i])
        );
      end
    end

    assign q = stage_q[Depth-1];
  end

endmodule

// File: tb/tb_pipeline.sv
// Bench for the delay line: several depth/width configurations share one stimulus stream and are
// checked each cycle against an edge-history model of what each output must hold.
module tb_pipeline;

  localparam int MaxEdges = 1024;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [14:0] d = '0;
  logic        d_w1 = 1'b0;

  logic [14:0] q_d0, q_d1, q_d2, q_d3, q_d5;
  logic        q_w1;

  // Per-edge record of what each instance sampled; index 1 is the first rising edge.
  logic [14:0] hist_d   [0:MaxEdges];
  logic        hist_w1  [0:MaxEdges];
  logic        hist_rst [0:MaxEdges];
  int          n_edges   = 0;
  int          first_rst = 0;

  int errors = 0;
  int checks = 0;

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- DUTs ----------------
  pipeline #(.Width(15), .Depth(0)) u_d0 (.clk(clk), .rst(rst), .d(d),    .q(q_d0));
  pipeline #(.Width(15), .Depth(1)) u_d1 (.clk(clk), .rst(rst), .d(d),    .q(q_d1));
  pipeline #(.Width(15), .Depth(2)) u_d2 (.clk(clk), .rst(rst), .d(d),    .q(q_d2));
  pipeline #(.Width(15), .Depth(3)) u_d3 (.clk(clk), .rst(rst), .d(d),    .q(q_d3));
  pipeline #(.Width(15), .Depth(5)) u_d5 (.clk(clk), .rst(rst), .d(d),    .q(q_d5));
  pipeline #(.Width(1),  .Depth(4)) u_w1 (.clk(clk), .rst(rst), .d(d_w1), .q(q_w1));

  // ---------------- checking ----------------
  task automatic check_val(input string tag, input logic [14:0] act, input logic [14:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (after edge %0d)", tag, act, exp, n_edges);
    end
  endtask

  // Value a Depth-stage line holds after n_edges edges: the word sampled Depth-1 edges ago,
  // or zero if any reset edge fell within that window.
  function automatic logic [14:0] model_q(input int depth, input bit w1);
    int first;
    first = n_edges - depth + 1;
    for (int e = (first < 1 ? 1 : first); e <= n_edges; e++)
      if (hist_rst[e]) return '0;
    return w1 ? {14'b0, hist_w1[first]} : hist_d[first];
  endfunction

  task automatic check_all();
    if (first_rst > 0 && n_edges >= first_rst) begin
      check_val("depth1", q_d1, model_q(1, 1'b0));
      check_val("depth2", q_d2, model_q(2, 1'b0));
      check_val("depth3", q_d3, model_q(3, 1'b0));
      check_val("depth5", q_d5, model_q(5, 1'b0));
      check_val("width1_depth4", {14'b0, q_w1}, model_q(4, 1'b1));
    end
    check_val("depth0_pass", q_d0, d);
  endtask

  // ---------------- driver ----------------
  // Check outputs mid-cycle, apply new inputs, re-check the pass-through, then log the edge.
  task automatic cycle(input logic r, input logic [14:0] dv);
    @(negedge clk);
    check_all();
    rst  = r;
    d    = dv;
    d_w1 = ~d_w1;
    #1;
    check_val("depth0_pass_new", q_d0, d);
    @(posedge clk);
    n_edges++;
    hist_d[n_edges]   = d;
    hist_w1[n_edges]  = d_w1;
    hist_rst[n_edges] = rst;
    if (rst && first_rst == 0) first_rst = n_edges;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    // Reset held with all-ones on d.
    for (int i = 0; i < 10; i++) cycle(1'b1, 15'h7FFF);

    // Latency: 1, 2, 3 on consecutive edges.
    cycle(1'b0, 15'h0001);
    cycle(1'b0, 15'h0002);
    cycle(1'b0, 15'h0003);

    // Random stream.
    for (int i = 0; i < 100; i++) cycle(1'b0, 15'($urandom));

    // Random stream with sporadic resets.
    for (int i = 0; i < 40; i++)
      cycle(($urandom_range(0, 7) == 0), 15'($urandom));

    // Mid-stream single-cycle reset on a constant stream.
    for (int i = 0; i < 10; i++) cycle(1'b0, 15'h1234);
    cycle(1'b1, 15'h1234);
    for (int i = 0; i < 6; i++) cycle(1'b0, 15'h1234);

    // All-ones through every depth.
    for (int i = 0; i < 8; i++) cycle(1'b0, 15'h7FFF);

    @(negedge clk);
    check_all();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
